// File: rtl/cla_mp_add_sequencer.sv
// rtl/cla_mp_add_sequencer.sv - multi-precision adder serialized word by word through one 16-bit CLA
// Holds each word on the adder for SETTLE cycles, chaining the carry in a register between words.

module cla_adder16 (
  output logic [15:0] sum,
  output logic        carry_out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_c;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    logic [3:0] pp;
    logic [3:0] gg;
    logic [3:0] cc;

    assign pp = p[4*j +: 4];
    assign gg = g[4*j +: 4];

    assign grp_p[j] = &pp;
    assign grp_g[j] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0]);

    // Bit carries inside the group are resolved from the group carry-in in parallel.
    assign cc[0] = grp_c[j];
    assign cc[1] = gg[0] | (pp[0] & grp_c[j]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & grp_c[j]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & grp_c[j]);

    assign c[4*j +: 4] = cc;
  end

  assign grp_c[0] = carry_in;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & carry_in);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & carry_in);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & carry_in);
  assign carry_out = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & carry_in);

  assign sum = p ^ c;

endmodule

module cla_mp_add_sequencer #(
  parameter int WORDS  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   sum,
  output logic                  carry_out
);

  localparam int N = 16 * WORDS;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);
  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] sum_q, sum_d;
  logic [2:0]   idx_q, idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         carry_q, carry_d;
  logic         cout_q, cout_d;

  logic [6:0]   word_base;
  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic [15:0]  add_sum;
  logic         add_cout;

  // Adder inputs come only from registers so they stay frozen for the whole settle window.
  assign word_base = {idx_q, 4'b0000};
  assign add_a     = a_q[word_base +: 16];
  assign add_b     = b_q[word_base +: 16];

  cla_adder16 u_add (
    .sum       (add_sum),
    .carry_out (add_cout),
    .a         (add_a),
    .b         (add_b),
    .carry_in  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d                 = 4'd0;
          sum_d[word_base +: 16] = add_sum;
          carry_d               = add_cout;
          // idx wraps to 0 after the last word so the word select never leaves the operand.
          if (idx_q == LAST_IDX) begin
            cout_d  = add_cout;
            idx_d   = 3'd0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_cla_mp_add_sequencer.sv
// tb/tb_cla_mp_add_sequencer.sv - directed checks of cla_mp_add_sequencer (4x1 and 2x3 configs)

module tb_cla_mp_add_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [63:0] a1, b1, sum1;
  logic [31:0] a2, b2, sum2;
  logic        cin1, cin2;
  logic        busy1, done1, cout1;
  logic        busy2, done2, cout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_mp_add_sequencer #(.WORDS(4), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
  );

  cla_mp_add_sequencer #(.WORDS(2), .SETTLE(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .carry_in(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .carry_out(cout2)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic cv, output int lat);
    start1 = 1'b0;
    tick();
    a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("busy_after_accept", busy1, 1'b1);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (done1) begin
        lat = c;
        break;
      end
    end
  endtask

  int lat;
  int ndone;

  initial begin
    reset = 1'b1; start1 = 0; start2 = 0;
    a1 = '0; b1 = '0; cin1 = 0; a2 = '0; b2 = '0; cin2 = 0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_busy", busy1, 1'b0);
    check_eq("rst_done", done1, 1'b0);
    check_eq("rst_cout", cout1, 1'b0);
    check_eq("rst_sum", sum1, 64'd0);

    run_op(64'd10, 64'd22, 1'b0, lat);
    check_eq("basic_latency", lat, 4);
    check_eq("basic_sum", sum1, 64'd32);
    check_eq("basic_cout", cout1, 1'b0);
    tick();
    check_eq("done_one_cycle", done1, 1'b0);

    run_op(64'd10, 64'd22, 1'b1, lat);
    check_eq("cin_latency", lat, 4);
    check_eq("cin_sum", sum1, 64'd33);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, lat);
    check_eq("ripple_latency", lat, 4);
    check_eq("ripple_sum", sum1, 64'd0);
    check_eq("ripple_cout", cout1, 1'b1);

    run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, lat);
    check_eq("alt_sum", sum1, 64'h0001_0000_0001_0000);
    check_eq("alt_cout", cout1, 1'b0);

    // start pulses with new operands during the run are ignored
    tick();
    a1 = 64'h1234; b1 = 64'h1111; cin1 = 0; start1 = 1'b1;
    tick();
    a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = 64'hFFFF_FFFF_FFFF_FFFF; cin1 = 1;
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done1) ndone++;
    end
    start1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done1) begin
        ndone++;
        check_eq("busy_start_sum", sum1, 64'h2345);
        check_eq("busy_start_cout", cout1, 1'b0);
      end
    end
    check_eq("busy_start_ndone", ndone, 1);

    // reset after word 1 is captured aborts the operation
    a1 = 64'h1111_2222_3333_4444; b1 = 64'h0101_0202_0303_0404; cin1 = 0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick();
    ndone = 0;
    reset = 1'b1;
    tick();
    if (done1) ndone++;
    tick();
    if (done1) ndone++;
    reset = 1'b0;
    check_eq("abort_sum", sum1, 64'd0);
    check_eq("abort_busy", busy1, 1'b0);
    check_eq("abort_cout", cout1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done1) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    run_op(64'd10, 64'd22, 1'b0, lat);
    check_eq("after_abort_latency", lat, 4);
    check_eq("after_abort_sum", sum1, 64'd32);

    // SETTLE=3, WORDS=2: each word held three cycles, done six cycles after accept
    a2 = 32'h0001_FFFF; b2 = 32'd1; cin2 = 0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_eq("s3_busy", busy2, 1'b1);
    lat = -1;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) tick();
      if (c < 6) begin
        check_eq("s3_adder_a", dut2.add_a, (c < 3) ? 16'hFFFF : 16'h0001);
        check_eq("s3_adder_b", dut2.add_b, (c < 3) ? 16'h0001 : 16'h0000);
      end
      if (done2) begin
        lat = c;
        break;
      end
    end
    check_eq("s3_latency", lat, 6);
    check_eq("s3_sum", sum2, 32'h0002_0000);
    check_eq("s3_cout", cout2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
